// File: rtl/bpred_pkg.sv
// bpred_pkg: shared types, constants and counter update helper for the branch predictor
package bpred_pkg;
  localparam int BHT_IDX_W = 4;
  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_MAX = 2'b11;
  typedef enum logic {RUN, FLUSH} bpred_state_t;
  typedef struct packed {
    logic valid;
    logic is_branch;
    logic [BHT_IDX_W-1:0] idx;
    logic pred;
  } qentry_t;
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    return taken ? (ctr == CTR_MAX ? CTR_MAX : ctr + 2'd1) : (ctr == 2'd0 ? 2'd0 : ctr - 2'd1);
  endfunction
endpackage

// File: rtl/bht_counter_table.sv
// bht_counter_table: 2-bit saturating counters, one combinational read and one synchronous update port
module bht_counter_table
  import bpred_pkg::*;
#(
  parameter int IDX_W = BHT_IDX_W
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);
  logic [1:0] ctr [2**IDX_W];
  assign rd_ctr = ctr[rd_idx];
  always_ff @(posedge clk) begin
    if (!nReset) begin
      for (int i = 0; i < 2**IDX_W; i++) ctr[i] <= CTR_RESET;
    end else if (upd_en) begin
      ctr[upd_idx] <= sat_update(ctr[upd_idx], upd_taken);
    end
  end
endmodule

// File: rtl/bpred_ctrl.sv
// bpred_ctrl: BHT prediction, in-flight tracking, mispredict recovery and statistics
module bpred_ctrl
  import bpred_pkg::*;
#(
  parameter int PSIZE        = 6,
  parameter int IDX_W        = BHT_IDX_W,
  parameter int PIPE_DEPTH   = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             fetch_valid,
  input  logic             fetch_is_branch,
  input  logic [PSIZE-1:0] fetch_pc,
  input  logic             stall,
  input  logic             ex_resolve,
  input  logic             branch_actual,
  output logic             pred_take,
  output logic             redirect,
  output logic             redirect_taken,
  output logic             flush,
  output logic [15:0]      mispredict_cnt,
  output logic [15:0]      branch_cnt,
  output logic             seq_err
);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  bpred_state_t state;
  logic [CW-1:0] cnt;
  qentry_t q [PIPE_DEPTH];
  qentry_t head, tail;
  logic [1:0] rd_ctr;
  logic [IDX_W-1:0] fidx;
  logic hit, mis, unused_pc;
  assign fidx = fetch_pc[IDX_W-1:0];
  assign unused_pc = ^fetch_pc[PSIZE-1:IDX_W];
  assign pred_take = fetch_is_branch & rd_ctr[1];
  assign head = q[PIPE_DEPTH-1];
  assign tail = '{valid: fetch_valid, is_branch: fetch_is_branch, idx: fidx, pred: pred_take};
  assign hit = ex_resolve & head.valid & head.is_branch;
  assign mis = hit & (head.pred != branch_actual);
  bht_counter_table #(.IDX_W(IDX_W)) u_bht (
    .clk      (clk),
    .nReset   (nReset),
    .rd_idx   (fidx),
    .rd_ctr   (rd_ctr),
    .upd_en   (hit),
    .upd_idx  (head.idx),
    .upd_taken(branch_actual)
  );
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state <= RUN;
      cnt <= '0;
      redirect <= 1'b0;
      redirect_taken <= 1'b0;
      flush <= 1'b0;
      seq_err <= 1'b0;
      branch_cnt <= '0;
      mispredict_cnt <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) q[i] <= '0;
    end else begin
      redirect <= mis;
      redirect_taken <= mis & branch_actual;
      if (ex_resolve && !hit) seq_err <= 1'b1;
      if (hit && branch_cnt != 16'hFFFF) branch_cnt <= branch_cnt + 16'd1;
      if (mis && mispredict_cnt != 16'hFFFF) mispredict_cnt <= mispredict_cnt + 16'd1;
      if (mis) begin
        state <= FLUSH;
        cnt <= CW'(FLUSH_CYCLES - 1);
        flush <= 1'b1;
        for (int i = 0; i < PIPE_DEPTH; i++) q[i] <= '0;
      end else if (state == FLUSH) begin
        for (int i = 0; i < PIPE_DEPTH; i++) q[i] <= '0;
        state <= cnt == '0 ? RUN : FLUSH;
        flush <= cnt != '0;
        cnt <= cnt == '0 ? cnt : cnt - 1'b1;
      end else if (!stall) begin
        for (int i = PIPE_DEPTH - 1; i > 0; i--) q[i] <= q[i-1];
        q[0] <= tail;
      end
    end
  end
endmodule

// File: tb/tb_bpred_ctrl.sv
// tb_bpred_ctrl: directed and randomized checks of bpred_ctrl against a queue-based reference model
module tb_bpred_ctrl;
  localparam int PSIZE = 6, IDX_W = 4, PD = 2, FC = 2;
  logic clk = 0, nReset = 0, fetch_valid = 0, fetch_is_branch = 0, stall = 0, ex_resolve = 0, branch_actual = 0;
  logic [PSIZE-1:0] fetch_pc = '0;
  logic pred_take, redirect, redirect_taken, flush, seq_err;
  logic [15:0] mispredict_cnt, branch_cnt;
  always #5 clk = ~clk;
  bpred_ctrl #(.PSIZE(PSIZE), .IDX_W(IDX_W), .PIPE_DEPTH(PD), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .nReset(nReset), .fetch_valid(fetch_valid), .fetch_is_branch(fetch_is_branch),
    .fetch_pc(fetch_pc), .stall(stall), .ex_resolve(ex_resolve), .branch_actual(branch_actual),
    .pred_take(pred_take), .redirect(redirect), .redirect_taken(redirect_taken), .flush(flush),
    .mispredict_cnt(mispredict_cnt), .branch_cnt(branch_cnt), .seq_err(seq_err)
  );
  int n_tests = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  typedef struct {bit v; bit br; int idx; bit pred;} ment_t;
  ment_t mq[$];
  int bht[16];
  int m_bc, m_mc, flush_left;
  bit m_se, m_rd, m_rt;
  function automatic void clear_q();
    mq.delete();
    repeat (PD) mq.push_back('{0, 0, 0, 0});
  endfunction
  function automatic void model_reset();
    foreach (bht[i]) bht[i] = 1;
    clear_q();
    m_bc = 0; m_mc = 0; flush_left = 0; m_se = 0; m_rd = 0; m_rt = 0;
  endfunction
  task automatic tick();
    int ix;
    bit mp, hit, mis;
    ment_t h;
    ix = int'(fetch_pc) % 16;
    mp = fetch_is_branch && bht[ix] >= 2;
    #1 check("pred_take", pred_take, 32'(mp));
    if (!nReset) model_reset();
    else begin
      h = mq[0];
      hit = ex_resolve && h.v && h.br;
      mis = hit && (h.pred != branch_actual);
      if (ex_resolve && !hit) m_se = 1;
      if (hit) begin
        bht[h.idx] = branch_actual ? (bht[h.idx] < 3 ? bht[h.idx] + 1 : 3) : (bht[h.idx] > 0 ? bht[h.idx] - 1 : 0);
        if (m_bc < 65535) m_bc++;
      end
      if (mis && m_mc < 65535) m_mc++;
      m_rd = mis;
      m_rt = mis && branch_actual;
      if (mis) begin clear_q(); flush_left = FC; end
      else if (flush_left > 0) begin clear_q(); flush_left--; end
      else if (!stall) begin
        void'(mq.pop_front());
        mq.push_back('{fetch_valid, fetch_is_branch, ix, mp});
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("redirect", redirect, 32'(m_rd));
    check("redirect_taken", redirect_taken, 32'(m_rt));
    check("flush", flush, 32'(flush_left > 0));
    check("seq_err", seq_err, 32'(m_se));
    check("branch_cnt", branch_cnt, 32'(m_bc));
    check("mispredict_cnt", mispredict_cnt, 32'(m_mc));
  endtask
  task automatic drive(input bit fv, input bit fb, input int pc, input bit st, input bit er, input bit ba);
    fetch_valid = fv; fetch_is_branch = fb; fetch_pc = PSIZE'(pc);
    stall = st; ex_resolve = er; branch_actual = ba;
    tick();
  endtask
  task automatic do_reset();
    nReset = 0;
    drive(0, 0, 0, 0, 0, 0);
    nReset = 1;
  endtask
  task automatic check_bht(input string tag);
    for (int i = 0; i < 16; i++) check(tag, 32'(dut.u_bht.ctr[i]), 32'(bht[i]));
  endtask
  initial begin
    model_reset();
    do_reset();
    // not-taken resolve on a fresh entry
    drive(1, 1, 5, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    check("A_redirect", redirect, 0);
    check("A_bc", branch_cnt, 1);
    check("A_bht5", 32'(dut.u_bht.ctr[5]), 0);
    do_reset();
    drive(1, 1, 5, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1);
    check("B_redirect", redirect, 1);
    check("B_rt", redirect_taken, 1);
    check("B_flush0", flush, 1);
    check("B_mc", mispredict_cnt, 1);
    check("B_bht5", 32'(dut.u_bht.ctr[5]), 2);
    drive(1, 1, 5, 0, 0, 0);
    check("B_pulse", redirect, 0);
    check("B_flush1", flush, 1);
    drive(1, 1, 5, 0, 0, 0);
    check("B_flush2", flush, 0);
    drive(0, 0, 0, 0, 1, 0);
    check("B_empty", seq_err, 1);
    fetch_valid = 1; fetch_is_branch = 1; fetch_pc = 6'h05; ex_resolve = 0; stall = 0;
    #1 check("B_pred1", pred_take, 1);
    drive(1, 1, 5, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1);
    check("B_bht11", 32'(dut.u_bht.ctr[5]), 3);
    drive(1, 1, 5, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1);
    check("B_sat", 32'(dut.u_bht.ctr[5]), 3);
    drive(1, 1, 5, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    check("C_redirect", redirect, 1);
    check("C_rt", redirect_taken, 0);
    check("C_bht10", 32'(dut.u_bht.ctr[5]), 2);
    repeat (3) drive(0, 0, 0, 0, 0, 0);
    do_reset();
    drive(1, 1, 3, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0);
    check("D_seq_err", seq_err, 1);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    check("D_bc", branch_cnt, 1);
    check("D_no_redirect", redirect, 0);
    repeat (3) drive(0, 0, 0, 0, 0, 0);
    check("D_sticky", seq_err, 1);
    drive(1, 1, 9, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1);
    check("E_flush", flush, 1);
    nReset = 0;
    drive(0, 0, 0, 0, 0, 0);
    check("E_flush_rst", flush, 0);
    check("E_redirect_rst", redirect, 0);
    check("E_bc", branch_cnt, 0);
    check("E_mc", mispredict_cnt, 0);
    check("E_seq", seq_err, 0);
    for (int i = 0; i < 16; i++) check("E_bht01", 32'(dut.u_bht.ctr[i]), 1);
    nReset = 1;
    for (int c = 0; c < 3000; c++) begin
      bit er;
      int hidx;
      nReset = ($urandom_range(0, 299) != 0);
      hidx = mq[0].idx;
      er = (mq[0].v && mq[0].br) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 99) < 3);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, int'($urandom_range(0, 63)),
            $urandom_range(0, 4) == 0, er,
            ($urandom_range(0, 3) != 0) ? hidx[0] : bit'($urandom_range(0, 1)));
      if (c % 500 == 499) check_bht("R_bht");
    end
    nReset = 1;
    check_bht("final_bht");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bpred_ctrl.md
Name: bpred_ctrl

Overview:
- Branch prediction controller for the picoMIPS pipeline.
- Holds a 2-bit saturating-counter branch history table (BHT) indexed by fetch PC and supplies a taken/not-taken prediction to the PC unit.
- Tracks in-flight predictions up to the execute stage and detects mispredicts in both directions.
- On a mispredict, sequences the recovery: one redirect pulse plus a multi-cycle pipeline flush.

Parameters:
- PSIZE, 6, program counter width in bits.
- IDX_W, 4, BHT index width; table holds 2**IDX_W entries; index = fetch_pc[IDX_W-1:0].
- PIPE_DEPTH, 2, number of cycles from fetch to branch resolution; this is the in-flight queue depth.
- FLUSH_CYCLES, 2, number of cycles flush is held after a mispredict (>=1).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- nReset  in  1  synchronous, active-low reset.
- fetch_valid  in  1  an instruction is fetched this cycle.
- fetch_is_branch  in  1  the fetched instruction is a conditional branch (predecode).
- fetch_pc  in  PSIZE  PC of the fetched instruction.
- stall  in  1  pipeline stall; freezes the queue and ignores fetch.
- ex_resolve  in  1  the branch at the queue head resolves this cycle.
- branch_actual  in  1  actual outcome of the resolving branch; 1 = taken.
- pred_take  out  1  prediction for the current fetch_pc (combinational).
- redirect  out  1  one-cycle pulse requesting a PC correction (registered).
- redirect_taken  out  1  valid with redirect: 1 = go to the branch target, 0 = go to fall-through.
- flush  out  1  invalidate younger pipeline stages (registered).
- mispredict_cnt  out  16  saturating count of mispredicts.
- branch_cnt  out  16  saturating count of resolved branches.
- seq_err  out  1  sticky error flag: ex_resolve arrived with no valid branch at the queue head.

Behaviour:
- Reset, while nReset=0 at a clk edge:
  - All BHT entries set to 2'b01 (weakly not-taken).
  - Queue cleared.
  - FSM set to RUN.
  - redirect, redirect_taken, flush, seq_err all 0; both counters 0.
  - Reset mid-flush abandons the flush immediately.
- Prediction:
  - pred_take = BHT[fetch_pc[IDX_W-1:0]][1] when fetch_is_branch, else 0.
  - No bypass: a same-cycle update to the same index is not visible to the lookup.
- Queue:
  - Shift register of PIPE_DEPTH entries {valid, is_branch, idx, pred}; the head is the oldest entry.
  - Each unstalled cycle in RUN: shift by one; the tail loads {fetch_valid, fetch_is_branch, idx, pred_take}.
  - With stall=1: the queue holds and fetch is ignored.
  - An entry therefore reaches the head PIPE_DEPTH unstalled cycles after its fetch.
- Resolution, evaluated at the head when ex_resolve=1:
  - If head.valid and head.is_branch: update BHT[head.idx] saturating. Taken increments (3 holds at 3); not-taken decrements (0 holds at 0). Increment branch_cnt, saturating at 16'hFFFF.
  - Mispredict = head.pred != branch_actual; covers both taken/not-taken directions. On mispredict also increment mispredict_cnt (saturating).
  - If the head is not a valid branch: set seq_err, with no BHT or counter change.
  - ex_resolve is honoured even when stall=1.
- FSM states RUN and FLUSH, with a down-counter of width $clog2(FLUSH_CYCLES+1):
  - RUN, mispredict at edge t:
    - At t, all queue entries are invalidated; the tail load is suppressed.
    - Next state FLUSH; counter = FLUSH_CYCLES-1.
    - From t, redirect=1 for exactly one cycle, with redirect_taken=branch_actual.
    - From t, flush=1.
  - FLUSH:
    - flush=1; fetch_valid is ignored and the queue loads invalid entries.
    - When counter==0, next state is RUN and flush drops; otherwise the counter decrements.
    - flush is high for exactly FLUSH_CYCLES cycles.
  - ex_resolve in FLUSH: the queue is empty, so seq_err is set.
  - stall does not extend FLUSH.
- Simultaneous events:
  - Mispredict and stall together: mispredict wins and the queue is cleared.
  - BHT update and lookup on the same index: the lookup uses the pre-update value.

Decomposition:
- Package bpred_pkg holds:
  - typedef enum {RUN, FLUSH} bpred_state_t.
  - typedef struct qentry_t {valid, is_branch, idx, pred}.
  - Constants CTR_RESET=2'b01 and CTR_MAX=2'b11.
- Sub-module bht_counter_table:
  - Array of 2-bit counters with one combinational read port and one synchronous saturating update port.
  - Reset to CTR_RESET.
- Top level holds the queue, FSM and statistics counters.

Test Plan:
- Reset, then fetch a branch at pc=6'h05 -> pred_take=0; after PIPE_DEPTH=2 cycles, ex_resolve with branch_actual=0 -> no redirect; BHT[5]=00; branch_cnt=1.
- Resolve taken twice at idx 5 -> BHT[5] goes 01→10→11; next fetch at pc 5 gives pred_take=1; a third taken leaves it at 11 (saturation).
- Predict 0 then actual=1 -> redirect pulses for 1 cycle with redirect_taken=1; flush high for exactly 2 cycles; queue empty; mispredict_cnt=1; fetch during flush is not queued.
- Predict 1 (BHT=11) then actual=0 -> redirect_taken=0; BHT goes to 10.
- stall=1 for 3 cycles between fetch and resolve -> the entry reaches the head only after 2 unstalled cycles; ex_resolve at the wrong time sets seq_err, which stays set until reset.
- Drive nReset=0 during FLUSH -> flush=0 and redirect=0 at the next edge; all BHT entries read 01; both counters are 0.
